// File: rtl/rand_request_arbiter.sv
// rand_request_arbiter
//   Shares one free-running random source among NUM_REQ requesters using
//   round-robin arbitration. Each grant returns one value bounded to the
//   requester's exclusive limit by rejection sampling, with a fallback of 0
//   once MAX_TRIES samples have been rejected.
//   Optional feature macro: RAND_STATS_EN adds a saturating reject counter
//   output (reject_cnt) that counts rejected samples which stay in SAMPLE.
module rand_request_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int WIDTH     = 7,
  parameter int MAX_TRIES = 8
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic [WIDTH-1:0]         rand_in,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*WIDTH-1:0] limit,
  output logic [NUM_REQ-1:0]       gnt,
  output logic                     rnd_valid,
  output logic [WIDTH-1:0]         rnd_out,
  output logic                     rnd_fallback,
  output logic                     busy
`ifdef RAND_STATS_EN
  ,
  output logic [15:0]              reject_cnt
`endif
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int TRY_W = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
  localparam logic [TRY_W-1:0] LAST_TRY = TRY_W'(MAX_TRIES - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SAMPLE = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   cur_idx_q, cur_idx_d;
  logic [IDX_W-1:0]   last_idx_q, last_idx_d;
  logic [WIDTH-1:0]   lim_q, lim_d;
  logic [TRY_W-1:0]   tries_q, tries_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic               rnd_valid_q, rnd_valid_d;
  logic [WIDTH-1:0]   rnd_out_q, rnd_out_d;
  logic               rnd_fallback_q, rnd_fallback_d;
  logic               busy_q, busy_d;

  logic               arb_found_s;
  logic [IDX_W-1:0]   arb_idx_s;
  logic               accept_s;

  // Round-robin pick: first set request scanning upward from last_idx+1.
  always_comb begin : arb_scan
    int cand;
    logic [IDX_W-1:0] cand_idx;
    cand        = 0;
    cand_idx    = '0;
    arb_found_s = 1'b0;
    arb_idx_s   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = int'(last_idx_q) + k;
      if (cand >= NUM_REQ) begin
        cand = cand - NUM_REQ;
      end else begin
        cand = cand;
      end
      cand_idx = IDX_W'(cand);
      if (!arb_found_s && req[cand_idx]) begin
        arb_found_s = 1'b1;
        arb_idx_s   = cand_idx;
      end else begin
        arb_found_s = arb_found_s;
      end
    end
  end

  // A limit of zero means the full range, so every sample is accepted.
  always_comb begin
    accept_s = (lim_q == '0) || (rand_in < lim_q);
  end

  // Next-state and registered-output computation for the grant FSM.
  always_comb begin
    state_d        = state_q;
    cur_idx_d      = cur_idx_q;
    last_idx_d     = last_idx_q;
    lim_d          = lim_q;
    tries_d        = tries_q;
    gnt_d          = gnt_q;
    rnd_valid_d    = rnd_valid_q;
    rnd_out_d      = rnd_out_q;
    rnd_fallback_d = rnd_fallback_q;
    busy_d         = busy_q;
    case (state_q)
      ST_IDLE: begin
        if (arb_found_s) begin
          state_d   = ST_SAMPLE;
          cur_idx_d = arb_idx_s;
          lim_d     = limit[arb_idx_s*WIDTH +: WIDTH];
          tries_d   = '0;
          busy_d    = 1'b1;
        end else begin
          busy_d    = 1'b0;
        end
      end
      ST_SAMPLE: begin
        if (!req[cur_idx_q]) begin
          // Requester withdrew: abort without a result, keep last_idx.
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end else if (accept_s) begin
          state_d        = ST_DONE;
          rnd_out_d      = rand_in;
          rnd_fallback_d = 1'b0;
          rnd_valid_d    = 1'b1;
          gnt_d          = NUM_REQ'(1) << cur_idx_q;
        end else if (tries_q == LAST_TRY) begin
          state_d        = ST_DONE;
          rnd_out_d      = '0;
          rnd_fallback_d = 1'b1;
          rnd_valid_d    = 1'b1;
          gnt_d          = NUM_REQ'(1) << cur_idx_q;
        end else begin
          tries_d = tries_q + TRY_W'(1);
        end
      end
      ST_DONE: begin
        state_d        = ST_IDLE;
        last_idx_d     = cur_idx_q;
        rnd_valid_d    = 1'b0;
        rnd_fallback_d = 1'b0;
        gnt_d          = '0;
        busy_d         = 1'b0;
      end
      default: begin
        state_d        = ST_IDLE;
        rnd_valid_d    = 1'b0;
        rnd_fallback_d = 1'b0;
        gnt_d          = '0;
        busy_d         = 1'b0;
      end
    endcase
  end

  // Grant FSM state and registered outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q        <= ST_IDLE;
      cur_idx_q      <= '0;
      last_idx_q     <= LAST_IDX;
      lim_q          <= '0;
      tries_q        <= '0;
      gnt_q          <= '0;
      rnd_valid_q    <= 1'b0;
      rnd_out_q      <= '0;
      rnd_fallback_q <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      cur_idx_q      <= cur_idx_d;
      last_idx_q     <= last_idx_d;
      lim_q          <= lim_d;
      tries_q        <= tries_d;
      gnt_q          <= gnt_d;
      rnd_valid_q    <= rnd_valid_d;
      rnd_out_q      <= rnd_out_d;
      rnd_fallback_q <= rnd_fallback_d;
      busy_q         <= busy_d;
    end
  end

  assign gnt          = gnt_q;
  assign rnd_valid    = rnd_valid_q;
  assign rnd_out      = rnd_out_q;
  assign rnd_fallback = rnd_fallback_q;
  assign busy         = busy_q;

`ifdef RAND_STATS_EN
  logic        reject_s;
  logic [15:0] reject_cnt_q, reject_cnt_d;

  // Count rejects that keep sampling; the final fallback reject is excluded.
  always_comb begin
    reject_s = (state_q == ST_SAMPLE) && req[cur_idx_q] && !accept_s &&
               (tries_q != LAST_TRY);
    if (reject_s && (reject_cnt_q != 16'hFFFF)) begin
      reject_cnt_d = reject_cnt_q + 16'd1;
    end else begin
      reject_cnt_d = reject_cnt_q;
    end
  end

  // Saturating reject counter, cleared only by reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      reject_cnt_q <= 16'd0;
    end else begin
      reject_cnt_q <= reject_cnt_d;
    end
  end

  assign reject_cnt = reject_cnt_q;
`endif

endmodule

// File: tb/tb_rand_request_arbiter.sv
// Directed testbench for rand_request_arbiter (NUM_REQ=4, WIDTH=7, MAX_TRIES=8).
module tb_rand_request_arbiter;

  logic        clk = 1'b0;
  logic        resetn;
  logic [6:0]  rand_in;
  logic [3:0]  req;
  logic [27:0] limit;
  logic [3:0]  gnt;
  logic        rnd_valid;
  logic [6:0]  rnd_out;
  logic        rnd_fallback;
  logic        busy;
`ifdef RAND_STATS_EN
  logic [15:0] reject_cnt;
`endif

  int n_total = 0;
  int n_pass  = 0;

  rand_request_arbiter #(.NUM_REQ(4), .WIDTH(7), .MAX_TRIES(8)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .rand_in      (rand_in),
    .req          (req),
    .limit        (limit),
    .gnt          (gnt),
    .rnd_valid    (rnd_valid),
    .rnd_out      (rnd_out),
    .rnd_fallback (rnd_fallback),
    .busy         (busy)
`ifdef RAND_STATS_EN
    ,
    .reject_cnt   (reject_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One rising edge, then settle to the falling edge for checks and drives.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_lim(input int idx, input logic [6:0] val);
    limit[idx*7 +: 7] = val;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    req    = 4'b0000;
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
  endtask

  logic [3:0] exp_gnt;

  initial begin
    rand_in = 7'd0;
    limit   = 28'd0;
    req     = 4'b0000;
    resetn  = 1'b0;
    do_reset();

    // Reset state
    check("rst_valid", 32'(rnd_valid), 32'd0);
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_out", 32'(rnd_out), 32'd0);
    check("rst_fb", 32'(rnd_fallback), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
`ifdef RAND_STATS_EN
    check("rst_rejcnt", 32'(reject_cnt), 32'd0);
`endif

    // 1: first-try accept, valid two edges after the request is seen
    req = 4'b0001; set_lim(0, 7'd100); rand_in = 7'd37;
    step();
    check("t1_busy", 32'(busy), 32'd1);
    check("t1_nvalid", 32'(rnd_valid), 32'd0);
    step();
    check("t1_valid", 32'(rnd_valid), 32'd1);
    check("t1_gnt", 32'(gnt), 32'b0001);
    check("t1_out", 32'(rnd_out), 32'd37);
    check("t1_fb", 32'(rnd_fallback), 32'd0);
    do_reset();

    // 2: all requesting, full range: round-robin, one pulse every 3 clocks
    limit = 28'd0; rand_in = 7'd5; req = 4'b1111;
    exp_gnt = 4'b0001;
    for (int g = 0; g < 5; g++) begin
      step();
      check("t2_sample_nvalid", 32'(rnd_valid), 32'd0);
      step();
      check("t2_valid", 32'(rnd_valid), 32'd1);
      check("t2_gnt", 32'(gnt), 32'(exp_gnt));
      step();
      check("t2_idle_nvalid", 32'(rnd_valid), 32'd0);
      exp_gnt = {exp_gnt[2:0], exp_gnt[3]};
    end

    // 3: never accepted -> fallback after MAX_TRIES samples
    req = 4'b0001; set_lim(0, 7'd10); rand_in = 7'd120;
    for (int s = 0; s < 8; s++) step();
    check("t3_nvalid", 32'(rnd_valid), 32'd0);
    check("t3_busy", 32'(busy), 32'd1);
    step();
    check("t3_valid", 32'(rnd_valid), 32'd1);
    check("t3_out", 32'(rnd_out), 32'd0);
    check("t3_fb", 32'(rnd_fallback), 32'd1);
    check("t3_gnt", 32'(gnt), 32'b0001);
`ifdef RAND_STATS_EN
    check("t3_rejcnt", 32'(reject_cnt), 32'd7);
`endif
    req = 4'b0000;
    step();
    check("t3_fb_clr", 32'(rnd_fallback), 32'd0);

    // 4: two rejects then accept
    req = 4'b0100; set_lim(2, 7'd50); rand_in = 7'd90;
    step();
    step();
    rand_in = 7'd70;
    step();
    check("t4_nvalid", 32'(rnd_valid), 32'd0);
    rand_in = 7'd12;
    step();
    check("t4_valid", 32'(rnd_valid), 32'd1);
    check("t4_out", 32'(rnd_out), 32'd12);
    check("t4_gnt", 32'(gnt), 32'b0100);
    req = 4'b0000;
    step();

    // 5: request withdrawn mid-SAMPLE aborts; last_idx stays at 3
    do_reset();
    req = 4'b0001; set_lim(0, 7'd10); rand_in = 7'd120;
    step();
    step();
    check("t5_busy_sampling", 32'(busy), 32'd1);
    req = 4'b0000;
    step();
    check("t5_abort_nvalid", 32'(rnd_valid), 32'd0);
    check("t5_abort_busy", 32'(busy), 32'd0);
    req = 4'b0011; rand_in = 7'd3;
    step();
    step();
    check("t5_valid", 32'(rnd_valid), 32'd1);
    check("t5_gnt", 32'(gnt), 32'b0001);
    check("t5_out", 32'(rnd_out), 32'd3);
    req = 4'b0000;
    step();

    // 6: async reset during SAMPLE, then a clean first-try grant
    do_reset();
    req = 4'b1000; set_lim(3, 7'd100); rand_in = 7'd120;
    step();
    step();
    check("t6_busy_pre", 32'(busy), 32'd1);
    #2 resetn = 1'b0;
    #1;
    check("t6_rst_busy", 32'(busy), 32'd0);
    check("t6_rst_valid", 32'(rnd_valid), 32'd0);
    check("t6_rst_gnt", 32'(gnt), 32'd0);
    check("t6_rst_out", 32'(rnd_out), 32'd0);
`ifdef RAND_STATS_EN
    check("t6_rst_rejcnt", 32'(reject_cnt), 32'd0);
`endif
    @(negedge clk);
    resetn = 1'b1;
    rand_in = 7'd20;
    step();
    step();
    check("t6_valid", 32'(rnd_valid), 32'd1);
    check("t6_gnt", 32'(gnt), 32'b1000);
    check("t6_out", 32'(rnd_out), 32'd20);
    check("t6_fb", 32'(rnd_fallback), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
